// File: rtl/icache_sa2_pkg.sv
// Shared constants for the 2-way set-associative instruction cache.
package icache_sa2_pkg;

    localparam logic [1:0] IC_IDLE    = 2'd0;
    localparam logic [1:0] IC_REFILL  = 2'd1;
    localparam logic [1:0] IC_RESPOND = 2'd2;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid/tag and line words, with a combinational
// compare/read port and a single word-write port.
module icache_way #(
    parameter int INDEX_W = 4,
    parameter int OFFS_W  = 2,
    parameter int TAG_W   = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic [INDEX_W-1:0] i_rd_index,
    input  logic [OFFS_W-1:0]  i_rd_offs,
    input  logic [TAG_W-1:0]   i_cmp_tag,
    output logic               o_valid,
    output logic               o_hit,
    output logic [31:0]        o_rd_data,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [OFFS_W-1:0]  i_wr_offs,
    input  logic [31:0]        i_wr_data,
    input  logic               i_fill_done,
    input  logic [TAG_W-1:0]   i_fill_tag
);
    import icache_sa2_pkg::*;

    localparam int SETS  = 1 << INDEX_W;
    localparam int LINES = 1 << (INDEX_W + OFFS_W);

    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [LINES];

    // Valid bits: cleared by reset or flush, set when a line fill completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_clr) begin
            r_valid <= '0;
        end else if (i_fill_done) begin
            r_valid[i_wr_index] <= TRUE;
        end
    end

    // Tag and data storage carry no reset; validity gates their use.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[{i_wr_index, i_wr_offs}] <= i_wr_data;
        end
        if (i_fill_done) begin
            r_tag[i_wr_index] <= i_fill_tag;
        end
    end

    assign o_valid   = r_valid[i_rd_index];
    assign o_hit     = o_valid && (r_tag[i_rd_index] == i_cmp_tag);
    assign o_rd_data = r_data[{i_rd_index, i_rd_offs}];

endmodule

// File: rtl/icache_sa2.sv
// 2-way set-associative instruction cache with LRU replacement and an
// FSM that refills whole lines word by word from the memory controller.
module icache_sa2
    import icache_sa2_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 4,
    parameter int OFFS_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              IF_req,
    input  logic [ADDR_W-1:0] IF_Addr,
    output logic              IF_ok,
    output logic [31:0]       IF_Inst,
    output logic              MC_req,
    output logic [ADDR_W-1:0] MC_Addr,
    input  logic              MC_ok,
    input  logic [31:0]       MC_Data
);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFS_W - 2;
    localparam int SETS     = 1 << INDEX_W;
    localparam int INDEX_LO = OFFS_W + 2;
    localparam int TAG_LO   = INDEX_W + OFFS_W + 2;

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [OFFS_W-1:0]  r_cnt;
    logic               r_victim;
    logic [SETS-1:0]    r_lru;
    logic               r_if_ok;
    logic [31:0]        r_if_inst;
    logic               r_mc_req;
    logic [ADDR_W-1:0]  r_mc_addr;

    logic [ADDR_W-1:0]  w_addr;
    logic [INDEX_W-1:0] w_index;
    logic [OFFS_W-1:0]  w_offs;
    logic [TAG_W-1:0]   w_tag;
    logic               w_valid0, w_valid1, w_hit0, w_hit1;
    logic [31:0]        w_data0, w_data1;
    logic               w_hit, w_hit_way, w_victim;
    logic [31:0]        w_hit_data, w_fill_data;
    logic               w_word_wr, w_last, w_fill_done, w_clr;
    logic               w_unused;

    // Compare against the live fetch address in IDLE, else the latched miss address.
    always_comb begin
        if (r_state == IC_IDLE) begin
            w_addr = IF_Addr;
        end else begin
            w_addr = r_addr;
        end
    end

    assign w_index  = w_addr[TAG_LO-1:INDEX_LO];
    assign w_offs   = w_addr[INDEX_LO-1:2];
    assign w_tag    = w_addr[ADDR_W-1:TAG_LO];
    assign w_unused = ^w_addr[1:0];

    assign w_clr       = rdy && clr;
    assign w_word_wr   = rdy && !clr && (r_state == IC_REFILL) && MC_ok;
    assign w_last      = (r_cnt == {OFFS_W{1'b1}});
    assign w_fill_done = w_word_wr && w_last;

    icache_way #(.INDEX_W(INDEX_W), .OFFS_W(OFFS_W), .TAG_W(TAG_W)) u_way0 (
        .clk(clk), .rst(rst), .i_clr(w_clr),
        .i_rd_index(w_index), .i_rd_offs(w_offs), .i_cmp_tag(w_tag),
        .o_valid(w_valid0), .o_hit(w_hit0), .o_rd_data(w_data0),
        .i_wr_en(w_word_wr && !r_victim), .i_wr_index(w_index), .i_wr_offs(r_cnt),
        .i_wr_data(MC_Data), .i_fill_done(w_fill_done && !r_victim), .i_fill_tag(w_tag)
    );

    icache_way #(.INDEX_W(INDEX_W), .OFFS_W(OFFS_W), .TAG_W(TAG_W)) u_way1 (
        .clk(clk), .rst(rst), .i_clr(w_clr),
        .i_rd_index(w_index), .i_rd_offs(w_offs), .i_cmp_tag(w_tag),
        .o_valid(w_valid1), .o_hit(w_hit1), .o_rd_data(w_data1),
        .i_wr_en(w_word_wr && r_victim), .i_wr_index(w_index), .i_wr_offs(r_cnt),
        .i_wr_data(MC_Data), .i_fill_done(w_fill_done && r_victim), .i_fill_tag(w_tag)
    );

    // Hit selection, victim choice (first invalid way, else LRU) and refill readback.
    always_comb begin
        w_hit      = w_hit0 || w_hit1;
        w_hit_way  = !w_hit0;
        w_hit_data = w_hit0 ? w_data0 : w_data1;
        if (!w_valid0) begin
            w_victim = 1'b0;
        end else if (!w_valid1) begin
            w_victim = 1'b1;
        end else begin
            w_victim = r_lru[w_index];
        end
        w_fill_data = r_victim ? w_data1 : w_data0;
    end

    // Control FSM, LRU bits and registered outputs; rdy low freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IC_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_victim  <= 1'b0;
            r_lru     <= '0;
            r_if_ok   <= FALSE;
            r_if_inst <= 32'h0000_0000;
            r_mc_req  <= FALSE;
            r_mc_addr <= '0;
        end else if (rdy) begin
            if (clr) begin
                r_state  <= IC_IDLE;
                r_cnt    <= '0;
                r_if_ok  <= FALSE;
                r_mc_req <= FALSE;
            end else begin
                r_if_ok <= FALSE;
                case (r_state)
                    IC_IDLE: begin
                        if (IF_req) begin
                            r_addr <= IF_Addr;
                            if (w_hit) begin
                                r_if_ok        <= TRUE;
                                r_if_inst      <= w_hit_data;
                                r_lru[w_index] <= !w_hit_way;
                            end else begin
                                r_victim  <= w_victim;
                                r_state   <= IC_REFILL;
                                r_cnt     <= '0;
                                r_mc_req  <= TRUE;
                                r_mc_addr <= {w_tag, w_index, {OFFS_W{1'b0}}, 2'b00};
                            end
                        end
                    end
                    IC_REFILL: begin
                        if (MC_ok) begin
                            if (w_last) begin
                                r_lru[w_index] <= !r_victim;
                                r_mc_req       <= FALSE;
                                r_state        <= IC_RESPOND;
                            end else begin
                                r_cnt     <= r_cnt + OFFS_W'(1'b1);
                                r_mc_addr <= r_mc_addr + ADDR_W'(3'd4);
                            end
                        end
                    end
                    IC_RESPOND: begin
                        r_if_ok   <= TRUE;
                        r_if_inst <= w_fill_data;
                        r_state   <= IC_IDLE;
                    end
                    default: begin
                        r_state <= IC_IDLE;
                    end
                endcase
            end
        end
    end

    assign IF_ok   = r_if_ok;
    assign IF_Inst = r_if_inst;
    assign MC_req  = r_mc_req;
    assign MC_Addr = r_mc_addr;

endmodule

// File: tb/tb_icache_sa2.sv
// Scoreboard bench for icache_sa2: directed fetches push expected words,
// a negedge monitor pops and compares on every IF_ok pulse.
module tb_icache_sa2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clr = 1'b0;
    logic        IF_req = 1'b0;
    logic [31:0] IF_Addr = 32'h0;
    logic        IF_ok;
    logic [31:0] IF_Inst;
    logic        MC_req;
    logic [31:0] MC_Addr;
    logic        MC_ok = 1'b0;
    logic [31:0] MC_Data = 32'h0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];

    icache_sa2 dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .IF_req(IF_req), .IF_Addr(IF_Addr), .IF_ok(IF_ok), .IF_Inst(IF_Inst),
        .MC_req(MC_req), .MC_Addr(MC_Addr), .MC_ok(MC_ok), .MC_Data(MC_Data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every IF_ok pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && IF_ok === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_if_ok: got IF_Inst %h with nothing expected", IF_Inst);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (IF_Inst !== e) begin
                    errors++;
                    $display("FAIL if_inst: got %h expected %h", IF_Inst, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory image: line 0x1000 holds 0xA0..0xA3, all other words encode their address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h000_0100) begin
            return 32'h0000_00A0 + {30'h0, a[3:2]};
        end
        return {16'hD000, a[15:0]};
    endfunction

    task automatic drain(input string name);
        repeat (3) tick();
        check(name, sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] exp);
        sb.push_back(exp);
        IF_req = 1'b1; IF_Addr = addr;
        tick();
        IF_req = 1'b0;
        check("hit_no_mc_req", MC_req, 32'd0);
    endtask

    // Miss: serve a whole line; optionally stall (rdy low) or flush before word k.
    task automatic refill(input logic [31:0] addr, input logic [31:0] exp,
                          input int stall_at, input int clr_at);
        logic [31:0] line;
        line = {addr[31:4], 4'h0};
        if (clr_at < 0) sb.push_back(exp);
        IF_req = 1'b1; IF_Addr = addr;
        tick();
        IF_req = 1'b0; IF_Addr = 32'hDEAD_BEE0;
        check("mc_req_entry", MC_req, 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k == clr_at) begin
                clr = 1'b1; MC_ok = 1'b1; MC_Data = 32'hBAD0_BAD0;
                tick();
                clr = 1'b0; MC_ok = 1'b0;
                check("mc_req_after_clr", MC_req, 32'd0);
                repeat (3) tick();
                return;
            end
            if (k == stall_at) begin
                rdy = 1'b0;
                repeat (3) begin
                    tick();
                    check("stall_mc_addr", MC_Addr, line + 32'(4 * k));
                    check("stall_mc_req", MC_req, 32'd1);
                end
                rdy = 1'b1;
            end
            for (int w = 0; w < 8 && MC_req !== 1'b1; w++) tick();
            if (MC_req !== 1'b1) begin
                check("mc_req_timeout", MC_req, 32'd1);
                return;
            end
            check("mc_addr", MC_Addr, line + 32'(4 * k));
            MC_ok = 1'b1; MC_Data = mem_word(line + 32'(4 * k));
            tick();
            MC_ok = 1'b0;
        end
        check("mc_req_done", MC_req, 32'd0);
        drain("if_ok_missing_after_refill");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #3;
        check("reset_if_ok", IF_ok, 32'd0);
        check("reset_if_inst", IF_Inst, 32'd0);
        check("reset_mc_req", MC_req, 32'd0);
        check("reset_mc_addr", MC_Addr, 32'd0);
        rst = 1'b0;
        tick();

        // Cold miss, then hits and back-to-back hits.
        refill(32'h0000_1004, 32'h0000_00A1, -1, -1);
        fetch_hit(32'h0000_100C, 32'h0000_00A3);
        drain("if_ok_missing_hit");
        sb.push_back(32'h0000_00A0);
        sb.push_back(32'h0000_00A2);
        IF_req = 1'b1; IF_Addr = 32'h0000_1000;
        tick();
        IF_Addr = 32'h0000_1008;
        tick();
        IF_req = 1'b0;
        check("b2b_no_mc_req", MC_req, 32'd0);
        drain("if_ok_missing_b2b");
        check("if_inst_hold", IF_Inst, 32'h0000_00A2);

        // Associativity and LRU replacement in set 0.
        refill(32'h0000_2000, 32'hD000_2000, -1, -1);
        fetch_hit(32'h0000_1000, 32'h0000_00A0);
        drain("if_ok_missing_lru1");
        refill(32'h0000_3008, 32'hD000_3008, -1, -1);
        fetch_hit(32'h0000_1004, 32'h0000_00A1);
        drain("if_ok_missing_lru2");
        fetch_hit(32'h0000_3000, 32'hD000_3000);
        drain("if_ok_missing_lru3");
        refill(32'h0000_2004, 32'hD000_2004, -1, -1);

        // Flush mid-refill; previously valid line must miss afterwards.
        refill(32'h0000_4000, 32'h0, -1, 2);
        check("no_if_ok_after_clr", sb.size(), 32'd0);
        refill(32'h0000_1000, 32'h0000_00A0, -1, -1);

        // rdy stall in REFILL (set 1).
        refill(32'h0000_5014, 32'hD000_5014, 1, -1);
        fetch_hit(32'h0000_501C, 32'hD000_501C);
        drain("if_ok_missing_stall_hit");

        // Async reset between edges in REFILL.
        IF_req = 1'b1; IF_Addr = 32'h0000_6000;
        tick();
        IF_req = 1'b0;
        check("rst_test_mc_req", MC_req, 32'd1);
        MC_ok = 1'b1; MC_Data = 32'hD000_6000;
        tick();
        MC_ok = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_mc_req", MC_req, 32'd0);
        check("async_rst_if_ok", IF_ok, 32'd0);
        check("async_rst_mc_addr", MC_Addr, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        refill(32'h0000_1004, 32'h0000_00A1, -1, -1);
        refill(32'h0000_5014, 32'hD000_5014, -1, -1);
        fetch_hit(32'h0000_100C, 32'h0000_00A3);
        drain("if_ok_missing_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_sa2.md
Name: icache_sa2

Overview:
- Parametrised successor to the combinational direct-mapped instruction cache.
- 2-way set-associative, multi-word lines, registered hit path, LRU replacement.
- Owns its own miss handling: an FSM refills a whole line from the memory controller through a word-level request/ok handshake.
- Sits between the IF stage and the memory controller. Supports flush on `clr` and freezes on `!rdy`.

Parameters:
- ADDR_W, 32, byte address width.
- INDEX_W, 4, set-index bits (sets = 2^INDEX_W).
- OFFS_W, 2, word-offset bits within a line (words per line = 2^OFFS_W).
- Derived (not overridable): TAG_W = ADDR_W - INDEX_W - OFFS_W - 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global ready; low freezes all state
- clr  in  1  synchronous flush (branch mispredict / fence.i); invalidates all lines, aborts refill
- IF_req  in  1  fetch request, sampled in IDLE
- IF_Addr  in  ADDR_W  fetch byte address, word aligned
- IF_ok  out  1  one-cycle pulse: IF_Inst valid for the latched request
- IF_Inst  out  32  fetched instruction
- MC_req  out  1  memory word-read request, held until MC_ok
- MC_Addr  out  ADDR_W  word address being refilled
- MC_ok  in  1  one-cycle pulse: MC_Data valid for current MC_Addr
- MC_Data  in  32  returned word

Behaviour:
- Address split: [1:0] ignored; offset = [OFFS_W+1:2]; index = next INDEX_W bits; tag = remaining upper bits.
- Storage per set: 2 ways × (valid, tag, 2^OFFS_W words), plus 1 LRU bit. The LRU bit names the way to evict.
- Reset (async): all valid=0, LRU=0, state=IDLE, IF_ok=0, IF_Inst=0, MC_req=0, MC_Addr=0, word counter=0.
- rdy=0: no state, array, or output register changes. Outputs hold their values. Applies in every state.
- clr=1 (with rdy=1), highest priority:
  - all valid=0 next edge; state=IDLE; MC_req=0; IF_ok=0 next cycle.
  - Any partially refilled line is discarded.
  - LRU bits are left unchanged.
- IDLE:
  - IF_req=1 latches IF_Addr and performs a combinational tag compare on both ways of the set.
  - Hit (valid && tag match) in way w:
    - next cycle IF_ok=1 and IF_Inst=word[offset].
    - LRU[set] = ~w.
    - Stays in IDLE, so back-to-back hits give throughput of 1 per cycle with latency 1.
  - Miss:
    - victim = first invalid way (way0 preferred), else the LRU way.
    - Go to REFILL; counter = 0; MC_req=1; MC_Addr = {tag, index, 0, 2'b00}.
- REFILL:
  - On each MC_ok: write MC_Data into victim word[counter].
  - If counter < max: counter+1; MC_Addr advances by 4; MC_req stays 1.
  - On the last word: set victim valid and tag; LRU[set] = ~victim; MC_req=0; go to RESPOND.
  - Words fill in line order from offset 0; there is no critical-word-first.
  - IF_req and IF_Addr changes are ignored during refill.
- RESPOND: one cycle. IF_ok=1, IF_Inst = refilled word[latched offset], then return to IDLE.
- IF_ok is a pulse and is 0 in all other cycles. IF_Inst holds its last value when IF_ok=0.
- Simultaneous clr and MC_ok: clr wins and the word is dropped.
- Index/tag aliasing across ways: never two valid ways with the same tag in one set, guaranteed by allocating only on miss.
- Miss latency = 2^OFFS_W memory words + 2 cycles (entry + RESPOND).

Decomposition:
- Shared defines header entries:
  - TAG/INDEX/OFFSET slice macros derived from the parameters.
  - True/False.
  - FSM state encodings IC_IDLE, IC_REFILL, IC_RESPOND.
- One natural sub-module: icache_way, one way's valid/tag/data arrays with a compare port and a word-write port. It is instantiated twice; LRU and FSM stay in the top.

Test Plan (defaults; line = 16 B, index = addr[7:4]):
- Cold miss: reset, IF_req with addr 0x1004 → MC_Addr sequence 0x1000, 0x1004, 0x1008, 0x100C. Memory returns 0xA0..0xA3 → IF_ok pulse with IF_Inst=0xA1, exactly once.
- Hit after fill: then request 0x100C → IF_ok next cycle with 0xA3, MC_req stays 0. Back-to-back 0x1000, 0x1008 → 0xA0, 0xA2 on consecutive cycles.
- Associativity/LRU:
  - Fill 0x1000 (way0) and 0x2000 (way1), both set 0; access 0x1000.
  - Miss on 0x3000 evicts 0x2000.
  - 0x1000 still hits; 0x2000 misses.
- Flush mid-refill: clr asserted after the 2nd MC_ok of a refill → MC_req drops next cycle, no IF_ok. A prior-valid line (0x1000) now misses.
- rdy stall: deassert rdy for 3 cycles during REFILL with MC_ok held low → MC_Addr, counter and state unchanged. Resuming completes normally with correct data.
- Async reset mid-REFILL: rst pulse between clock edges → MC_req=0 and IF_ok=0 immediately; all lines invalid afterward.
